// File: rtl/aes_mode_ctrl_if.sv
// aes_mode_ctrl_if: ready/valid stream bundle for the mode controller.
//   in_valid / in_ready / in_data    : message blocks into the controller
//   out_valid / out_ready / out_data : result blocks out of the controller
// Modports: master = message source/sink side, slave = controller side.
interface aes_mode_ctrl_if #(
    parameter int unsigned BLOCK_W = 128
) ();
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: ECB / CBC / CTR mode-of-operation controller wrapped around one
// block-cipher core with a start/done handshake. One block in flight at a time.
// Optional core watchdog: define AES_MODE_TIMEOUT_EN.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_cfg_*               : configuration, latched on i_cfg_load (IDLE only)
//   if_strm               : input/output block streams (slave modport)
//   o_core_* / i_core_*   : cipher core start/done handshake and data
//   o_busy                : controller not in IDLE
//   o_cfg_err             : sticky configuration / watchdog error
//   o_blk_count           : output blocks completed since the last valid load
module aes_mode_ctrl #(
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned KEY_W   = 128,
    parameter int unsigned CTR_W   = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cfg_load,
    input  logic [1:0]         i_cfg_mode,
    input  logic               i_cfg_decrypt,
    input  logic [KEY_W-1:0]   i_cfg_key,
    input  logic [BLOCK_W-1:0] i_cfg_iv,
    aes_mode_ctrl_if.slave     if_strm,
    output logic               o_core_start,
    output logic               o_core_decrypt,
    output logic [KEY_W-1:0]   o_core_key,
    output logic [BLOCK_W-1:0] o_core_din,
    input  logic               i_core_done,
    input  logic [BLOCK_W-1:0] i_core_dout,
    output logic               o_busy,
    output logic               o_cfg_err,
    output logic [CNT_W-1:0]   o_blk_count
);
    localparam logic [1:0] ModeCbc = 2'd1;
    localparam logic [1:0] ModeCtr = 2'd2;
    localparam logic [1:0] ModeRsv = 2'd3;

    if (CTR_W == 0 || CTR_W > BLOCK_W || TIMEOUT == 0) begin : g_param_check
        $error("aes_mode_ctrl: CTR_W must be 1..BLOCK_W and TIMEOUT nonzero");
    end

    typedef enum logic [1:0] {StIdle, StStart, StWait, StOut} state_e;

    state_e             r_state, w_state_nxt;
    logic               r_cfg_valid, w_cfg_valid_nxt;
    logic [1:0]         r_mode, w_mode_nxt;
    logic               r_decrypt, w_decrypt_nxt;
    logic [KEY_W-1:0]   r_key, w_key_nxt;
    logic [BLOCK_W-1:0] r_chain, w_chain_nxt;
    logic [BLOCK_W-1:0] r_ctr, w_ctr_nxt;
    logic [BLOCK_W-1:0] r_held_in, w_held_in_nxt;
    logic [BLOCK_W-1:0] r_core_din, w_core_din_nxt;
    logic               r_core_decrypt, w_core_decrypt_nxt;
    logic [BLOCK_W-1:0] r_out_data, w_out_data_nxt;
    logic [CNT_W-1:0]   r_blk_count, w_blk_count_nxt;
    logic               r_cfg_err, w_cfg_err_nxt;
    logic [BLOCK_W-1:0] w_ctr_inc;
    logic               w_in_ready;

`ifdef AES_MODE_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    logic [WdW-1:0] r_wd_cnt, w_wd_cnt_nxt;
`endif

    // A load in the same cycle as in_valid wins, so the block is not taken.
    assign w_in_ready         = (r_state == StIdle) && r_cfg_valid && !i_cfg_load;
    assign if_strm.in_ready   = w_in_ready;
    assign if_strm.out_valid  = (r_state == StOut);
    assign if_strm.out_data   = r_out_data;
    assign o_core_start       = (r_state == StStart);
    assign o_core_decrypt     = r_core_decrypt;
    assign o_core_key         = r_key;
    assign o_core_din         = r_core_din;
    assign o_busy             = (r_state != StIdle);
    assign o_cfg_err          = r_cfg_err;
    assign o_blk_count        = r_blk_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= StIdle;
            r_cfg_valid    <= 1'b0;
            r_mode         <= '0;
            r_decrypt      <= 1'b0;
            r_key          <= '0;
            r_chain        <= '0;
            r_ctr          <= '0;
            r_held_in      <= '0;
            r_core_din     <= '0;
            r_core_decrypt <= 1'b0;
            r_out_data     <= '0;
            r_blk_count    <= '0;
            r_cfg_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cfg_valid    <= w_cfg_valid_nxt;
            r_mode         <= w_mode_nxt;
            r_decrypt      <= w_decrypt_nxt;
            r_key          <= w_key_nxt;
            r_chain        <= w_chain_nxt;
            r_ctr          <= w_ctr_nxt;
            r_held_in      <= w_held_in_nxt;
            r_core_din     <= w_core_din_nxt;
            r_core_decrypt <= w_core_decrypt_nxt;
            r_out_data     <= w_out_data_nxt;
            r_blk_count    <= w_blk_count_nxt;
            r_cfg_err      <= w_cfg_err_nxt;
        end
    end

`ifdef AES_MODE_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= w_wd_cnt_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt        = r_state;
        w_cfg_valid_nxt    = r_cfg_valid;
        w_mode_nxt         = r_mode;
        w_decrypt_nxt      = r_decrypt;
        w_key_nxt          = r_key;
        w_chain_nxt        = r_chain;
        w_ctr_nxt          = r_ctr;
        w_held_in_nxt      = r_held_in;
        w_core_din_nxt     = r_core_din;
        w_core_decrypt_nxt = r_core_decrypt;
        w_out_data_nxt     = r_out_data;
        w_blk_count_nxt    = r_blk_count;
        w_cfg_err_nxt      = r_cfg_err;
`ifdef AES_MODE_TIMEOUT_EN
        w_wd_cnt_nxt       = r_wd_cnt;
`endif
        // Only the low counter field steps; upper IV bits never see a carry.
        w_ctr_inc              = r_ctr;
        w_ctr_inc[CTR_W-1:0]   = r_ctr[CTR_W-1:0] + CTR_W'(1);

        if (i_cfg_load) begin
            if (r_state != StIdle) begin
                w_cfg_err_nxt = 1'b1;
            end else if (i_cfg_mode == ModeRsv) begin
                w_cfg_valid_nxt = 1'b0;
                w_cfg_err_nxt   = 1'b1;
            end else begin
                w_mode_nxt      = i_cfg_mode;
                w_decrypt_nxt   = i_cfg_decrypt;
                w_key_nxt       = i_cfg_key;
                w_chain_nxt     = i_cfg_iv;
                w_ctr_nxt       = i_cfg_iv;
                w_blk_count_nxt = '0;
                w_cfg_valid_nxt = 1'b1;
                w_cfg_err_nxt   = 1'b0;
            end
        end

        unique case (r_state)
            StIdle: begin
                if (w_in_ready && if_strm.in_valid) begin
                    w_held_in_nxt = if_strm.in_data;
                    case (r_mode)
                        ModeCbc: w_core_din_nxt = r_decrypt ? if_strm.in_data
                                                            : if_strm.in_data ^ r_chain;
                        ModeCtr: w_core_din_nxt = r_ctr;
                        default: w_core_din_nxt = if_strm.in_data;
                    endcase
                    w_core_decrypt_nxt = (r_mode == ModeCtr) ? 1'b0 : r_decrypt;
                    w_state_nxt        = StStart;
                end
            end
            StStart: begin
                w_state_nxt = StWait;
`ifdef AES_MODE_TIMEOUT_EN
                w_wd_cnt_nxt = '0;
`endif
            end
            StWait: begin
                if (i_core_done) begin
                    case (r_mode)
                        ModeCbc: begin
                            if (r_decrypt) begin
                                w_out_data_nxt = i_core_dout ^ r_chain;
                                w_chain_nxt    = r_held_in;
                            end else begin
                                w_out_data_nxt = i_core_dout;
                                w_chain_nxt    = i_core_dout;
                            end
                        end
                        ModeCtr: begin
                            w_out_data_nxt = i_core_dout ^ r_held_in;
                            w_ctr_nxt      = w_ctr_inc;
                        end
                        default: w_out_data_nxt = i_core_dout;
                    endcase
                    w_state_nxt = StOut;
                end
`ifdef AES_MODE_TIMEOUT_EN
                else if (r_wd_cnt == WdW'(TIMEOUT - 1)) begin
                    // Core hung: drop the block and force a reload.
                    w_state_nxt     = StIdle;
                    w_cfg_err_nxt   = 1'b1;
                    w_cfg_valid_nxt = 1'b0;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + WdW'(1);
                end
`endif
            end
            StOut: begin
                if (if_strm.out_ready) begin
                    w_blk_count_nxt = r_blk_count + CNT_W'(1);
                    w_state_nxt     = StIdle;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Bench for aes_mode_ctrl. A stub core returns core_din ^ core_key a few cycles
// after core_start. Expected results are queued at issue time and checked by
// monitors whenever the DUT presents a result or a core start.
module tb_aes_mode_ctrl;
    localparam logic [127:0] K_A    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_A    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_A    = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] K_B    = {16{8'h0f}};
    localparam logic [127:0] IV_B   = {16{8'h55}};
    localparam logic [127:0] K_C    = 128'h000000000000000000000000000000ff;
    localparam logic [127:0] IV_C   = 128'h0123456789abcdef01234567ffffffff;
    localparam logic [127:0] CTR_O1 = 128'h0123456789abcdef01234567ffffff00;
    localparam logic [127:0] CTR_D2 = 128'h0123456789abcdef0123456700000000;
    localparam logic [127:0] CTR_O2 = 128'hfedcba9876543210fedcba98ffffff00;
    localparam logic [127:0] BP_IN  = {16{8'hf0}};
    localparam logic [127:0] BP_OUT = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] K_BAD  = {16{8'ha5}};
    localparam logic [127:0] ONES   = {16{8'hff}};

    typedef struct {
        logic [127:0] data;
        logic [15:0]  cnt;
    } exp_t;
    typedef struct {
        logic [127:0] din;
        logic         dec;
    } core_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cfg_load = 1'b0;
    logic [1:0]   cfg_mode = '0;
    logic         cfg_decrypt = 1'b0;
    logic [127:0] cfg_key = '0;
    logic [127:0] cfg_iv = '0;
    logic         core_start, core_decrypt;
    logic [127:0] core_key, core_din;
    logic         core_done = 1'b0;
    logic [127:0] core_dout = '0;
    logic         busy, cfg_err;
    logic [15:0]  blk_count;

    logic         stub_en = 1'b1;
    logic         spurious = 1'b0;
    logic         stub_busy = 1'b0;
    int           stub_cnt = 0;
    logic [127:0] stub_data = '0;

    int           n_vec = 0;
    int           n_err = 0;
    int           exp_cnt = 0;
    exp_t         exp_q[$];
    core_t        core_q[$];
    exp_t         mon_e;
    core_t        mon_c;

    aes_mode_ctrl_if #(.BLOCK_W(128)) strm ();

    aes_mode_ctrl #(
        .BLOCK_W(128), .KEY_W(128), .CTR_W(32), .CNT_W(16), .TIMEOUT(64)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_cfg_load     (cfg_load),
        .i_cfg_mode     (cfg_mode),
        .i_cfg_decrypt  (cfg_decrypt),
        .i_cfg_key      (cfg_key),
        .i_cfg_iv       (cfg_iv),
        .if_strm        (strm),
        .o_core_start   (core_start),
        .o_core_decrypt (core_decrypt),
        .o_core_key     (core_key),
        .o_core_din     (core_din),
        .i_core_done    (core_done),
        .i_core_dout    (core_dout),
        .o_busy         (busy),
        .o_cfg_err      (cfg_err),
        .o_blk_count    (blk_count)
    );

    always #5 clk = ~clk;

    // Stub core: not reset with the DUT, so an abandoned block still completes.
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start && stub_en) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 2;
            stub_data <= core_din ^ core_key;
        end else if (stub_busy) begin
            if (stub_cnt == 0) begin
                core_done <= 1'b1;
                core_dout <= stub_data;
                stub_busy <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end else if (spurious) begin
            core_done <= 1'b1;
            core_dout <= K_BAD;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Result and core-start monitors.
    always @(negedge clk) begin
        if (strm.out_valid && strm.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_unexpected: got %h, required no output", strm.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", strm.out_data, mon_e.data);
                check("blk_count_at_out", {112'd0, blk_count}, {112'd0, mon_e.cnt});
            end
        end
        if (core_start) begin
            if (core_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL core_start_unexpected: got din %h, required no start", core_din);
            end else begin
                mon_c = core_q.pop_front();
                check("core_din", core_din, mon_c.din);
                check("core_decrypt", {127'd0, core_decrypt}, {127'd0, mon_c.dec});
            end
        end
    end

    task automatic load_cfg(input logic [1:0] mode, input logic dec,
                            input logic [127:0] key, input logic [127:0] iv);
        cfg_mode    = mode;
        cfg_decrypt = dec;
        cfg_key     = key;
        cfg_iv      = iv;
        cfg_load    = 1'b1;
        @(posedge clk);
        #1 cfg_load = 1'b0;
        if (mode != 2'd3) exp_cnt = 0;
    endtask

    task automatic send_block(input logic [127:0] blk, input logic [127:0] exp_din,
                              input logic exp_dec, input logic [127:0] exp_out,
                              input bit want_out);
        bit ok;
        exp_t  e;
        core_t c;
        c.din = exp_din;
        c.dec = exp_dec;
        core_q.push_back(c);
        if (want_out) begin
            e.data = exp_out;
            e.cnt  = 16'(exp_cnt);
            exp_q.push_back(e);
            exp_cnt++;
        end
        strm.in_valid = 1'b1;
        strm.in_data  = blk;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (strm.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("in_ready_wait");
        @(posedge clk);
        #1 strm.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        strm.in_valid  = 1'b0;
        strm.in_data   = '0;
        strm.out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {127'd0, strm.in_ready}, 128'd0);
        check("rst_out_valid", {127'd0, strm.out_valid}, 128'd0);
        check("rst_core_start", {127'd0, core_start}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_cfg_err", {127'd0, cfg_err}, 128'd0);
        check("rst_blk_count", {112'd0, blk_count}, 128'd0);
        check("rst_out_data", strm.out_data, 128'd0);
        check("rst_core_din", core_din, 128'd0);
        check("rst_core_key", core_key, 128'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ECB encrypt and decrypt.
        load_cfg(2'd0, 1'b0, K_A, '0);
        @(negedge clk);
        check("ecb_in_ready", {127'd0, strm.in_ready}, 128'd1);
        check("ecb_core_key", core_key, K_A);
        @(posedge clk); #1;
        send_block(P_A, P_A, 1'b0, C_A, 1'b1);
        wait_idle("ecb_enc_drain");
        check("ecb_enc_count", {112'd0, blk_count}, 128'd1);
        @(posedge clk); #1;
        load_cfg(2'd0, 1'b1, K_A, '0);
        send_block(C_A, C_A, 1'b1, P_A, 1'b1);
        wait_idle("ecb_dec_drain");

        // CBC round trip; core_din on blocks 2 and 3 exposes the chain value.
        @(posedge clk); #1;
        load_cfg(2'd1, 1'b0, K_B, IV_B);
        send_block({16{8'h00}}, {16{8'h55}}, 1'b0, {16{8'h5a}}, 1'b1);
        send_block({16{8'hff}}, {16{8'ha5}}, 1'b0, {16{8'haa}}, 1'b1);
        send_block({16{8'h3c}}, {16{8'h96}}, 1'b0, {16{8'h99}}, 1'b1);
        wait_idle("cbc_enc_drain");
        check("cbc_enc_count", {112'd0, blk_count}, 128'd3);
        @(posedge clk); #1;
        load_cfg(2'd1, 1'b1, K_B, IV_B);
        send_block({16{8'h5a}}, {16{8'h5a}}, 1'b1, {16{8'h00}}, 1'b1);
        send_block({16{8'haa}}, {16{8'haa}}, 1'b1, {16{8'hff}}, 1'b1);
        send_block({16{8'h99}}, {16{8'h99}}, 1'b1, {16{8'h3c}}, 1'b1);
        wait_idle("cbc_dec_drain");

        // CTR with low-word wrap; decrypt bit set but must be forced to 0.
        @(posedge clk); #1;
        load_cfg(2'd2, 1'b1, K_C, IV_C);
        send_block(128'd0, IV_C, 1'b0, CTR_O1, 1'b1);
        send_block(ONES, CTR_D2, 1'b0, CTR_O2, 1'b1);
        wait_idle("ctr_drain");

        // Backpressure: result held for 10 cycles.
        @(posedge clk); #1;
        load_cfg(2'd0, 1'b0, K_A, '0);
        strm.out_ready = 1'b0;
        send_block(BP_IN, BP_IN, 1'b0, BP_OUT, 1'b1);
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (strm.out_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) bound_fail("bp_out_valid_wait");
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_out_data", strm.out_data, BP_OUT);
            check("bp_in_ready", {127'd0, strm.in_ready}, 128'd0);
            check("bp_blk_count", {112'd0, blk_count}, 128'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 strm.out_ready = 1'b1;
        wait_idle("bp_drain");
        check("bp_count_after", {112'd0, blk_count}, 128'd1);

        // cfg_load while WAIT: ignored, error flagged, block still completes.
        @(posedge clk); #1;
        send_block(P_A, P_A, 1'b0, C_A, 1'b1);
        @(posedge clk); #1;
        cfg_key  = K_BAD;
        cfg_load = 1'b1;
        @(posedge clk);
        #1 cfg_load = 1'b0;
        @(negedge clk);
        check("wait_load_err", {127'd0, cfg_err}, 128'd1);
        check("wait_load_key", core_key, K_A);
        wait_idle("wait_load_drain");
        check("wait_load_count", {112'd0, blk_count}, 128'd2);

        // Reserved mode: no acceptance, error stays set.
        @(posedge clk); #1;
        load_cfg(2'd3, 1'b0, K_A, '0);
        strm.in_valid = 1'b1;
        strm.in_data  = P_A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rsv_in_ready", {127'd0, strm.in_ready}, 128'd0);
        end
        check("rsv_cfg_err", {127'd0, cfg_err}, 128'd1);
        check("rsv_busy", {127'd0, busy}, 128'd0);
        @(posedge clk);
        #1 strm.in_valid = 1'b0;

        // A valid load clears the error.
        load_cfg(2'd0, 1'b0, K_A, '0);
        @(negedge clk);
        check("reload_cfg_err", {127'd0, cfg_err}, 128'd0);
        check("reload_in_ready", {127'd0, strm.in_ready}, 128'd1);
        check("reload_count", {112'd0, blk_count}, 128'd0);

        // cfg_load and in_valid together: load wins.
        @(posedge clk); #1;
        cfg_load      = 1'b1;
        strm.in_valid = 1'b1;
        strm.in_data  = P_A;
        @(negedge clk);
        check("both_in_ready", {127'd0, strm.in_ready}, 128'd0);
        @(posedge clk); #1;
        cfg_load      = 1'b0;
        strm.in_valid = 1'b0;
        @(negedge clk);
        check("both_busy", {127'd0, busy}, 128'd0);

        // Spurious core_done in IDLE.
        @(posedge clk); #1;
        spurious = 1'b1;
        @(posedge clk); #1;
        spurious = 1'b0;
        repeat (3) @(negedge clk);
        check("spur_busy", {127'd0, busy}, 128'd0);
        check("spur_out_valid", {127'd0, strm.out_valid}, 128'd0);

`ifdef AES_MODE_TIMEOUT_EN
        // Watchdog: START (1 cycle) + WAIT (64 cycles) then IDLE with error.
        begin
            int cyc;
            stub_en = 1'b0;
            send_block(P_A, P_A, 1'b0, '0, 1'b0);
            cyc = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (!busy) break;
                cyc++;
            end
            check("wd_busy_cycles", 128'(cyc), 128'd65);
            check("wd_cfg_err", {127'd0, cfg_err}, 128'd1);
            check("wd_in_ready", {127'd0, strm.in_ready}, 128'd0);
            check("wd_blk_count", {112'd0, blk_count}, 128'd0);
            stub_en = 1'b1;
        end
`endif

        // Reset while in WAIT; the core's late done must be ignored.
        @(posedge clk); #1;
        load_cfg(2'd0, 1'b0, K_A, '0);
        send_block(P_A, P_A, 1'b0, C_A, 1'b1);
        wait_idle("pre_rst_drain");
        @(posedge clk); #1;
        send_block(P_A, P_A, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("pre_rst_cfg_err", {127'd0, cfg_err}, 128'd1);
        check("pre_rst_busy", {127'd0, busy}, 128'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("wrst_in_ready", {127'd0, strm.in_ready}, 128'd0);
        check("wrst_out_valid", {127'd0, strm.out_valid}, 128'd0);
        check("wrst_core_start", {127'd0, core_start}, 128'd0);
        check("wrst_busy", {127'd0, busy}, 128'd0);
        check("wrst_cfg_err", {127'd0, cfg_err}, 128'd0);
        check("wrst_blk_count", {112'd0, blk_count}, 128'd0);
        check("wrst_out_data", strm.out_data, 128'd0);
        check("wrst_core_din", core_din, 128'd0);
        check("wrst_core_key", core_key, 128'd0);
        repeat (8) @(negedge clk);
        check("wrst_late_busy", {127'd0, busy}, 128'd0);

        check("exp_q_drained", 128'(exp_q.size()), 128'd0);
        check("core_q_drained", 128'(core_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
